decode_branch_unit: RTL
=======================

Name: decode_branch_unit

Overview:
- Decode-side counterpart of the instruction fetch stage.
- Accepts {if_id_instruc, if_id_nextpc} every cycle and resolves branches, jumps, jump-register and syscall.
- Drives the fetch redirect bus (id_if_*) and id_stall.
- Squashes wrong-path instructions and registers the surviving instruction into the ID/EX latch.

Parameters:
- EXC_VECTOR, 32'h0000_0040, exception target; fetch hardwires this value for selpctype 2'b11 and the two must match.
- SQUASH_CYCLES, 1, number of wrong-path fetch slots killed after a redirect. Legal values: 1..2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- if_id_instruc  in  32  instruction from fetch.
- if_id_nextpc  in  32  PC+4 of that instruction, or the redirect target.
- rf_rs_addr  out  5  register-file read address = instr[25:21] (combinational).
- rf_rt_addr  out  5  register-file read address = instr[20:16] (combinational).
- rf_rs_data  in  32  operand A.
- rf_rt_data  in  32  operand B.
- rs_busy  in  1  operand A is pending a write (scoreboard).
- rt_busy  in  1  operand B is pending a write (scoreboard).
- ex_stall  in  1  downstream cannot accept.
- id_stall  out  1  hold fetch.
- id_if_selpcsource  out  1  redirect request.
- id_if_selpctype  out  2  00 = PC-relative, 01 = register, 10 = absolute index, 11 = exception.
- id_if_pcimd2ext  out  32  nextpc + (sext(imm16) << 2).
- id_if_pcindex  out  32  {nextpc[31:28], instr[25:0], 2'b00}.
- id_if_rega  out  32  rf_rs_data.
- id_ex_instruc  out  32  registered instruction.
- id_ex_nextpc  out  32  registered nextpc.
- id_ex_valid  out  1  registered valid.

Behaviour:
- Classes, from opcode instr[31:26]:
  - BEQ = 000100, BNE = 000101 → type 00.
  - J = 000010, JAL = 000011 → type 10.
  - SPECIAL = 000000 with funct 001000 (JR) → type 01.
  - SPECIAL with funct 001100 (SYSCALL) → type 11.
  - Everything else: no redirect.
- Redirect outputs are combinational from the current instruction and operands; they are gated by state==RUN, by no operand hazard and by !ex_stall.
  - BEQ redirects iff rs==rt; BNE iff rs!=rt.
  - J, JAL, JR and SYSCALL always redirect.
- Operand hazard:
  - BEQ/BNE need rs and rt; JR needs rs.
  - If a needed busy bit is set: id_stall=1, no redirect, id_ex_valid<=0 (bubble), instruction held.
- id_stall = hazard | ex_stall.
- Arithmetic: all additions are 32-bit, modulo 2^32. sext fills instr[15] into bits 31:16.
- FSM, 3 states:
  - RUN: normal decode. A redirect goes to SQUASH with cnt=SQUASH_CYCLES; SYSCALL goes to EXC_WAIT instead.
  - SQUASH: each non-stalled cycle forces id_ex_valid<=0 and cnt--. At cnt==0 return to RUN. Redirect outputs are forced 0 in this state.
  - EXC_WAIT: one cycle with id_ex_valid<=0, then RUN. A second SYSCALL in the squash window is ignored.
- ID/EX latch:
  - In RUN without stall: instruc/nextpc captured and valid<=1.
  - While ex_stall: latch holds, FSM counters frozen.
  - When hazard && !ex_stall: latch loads a bubble (valid 0, instruc 0).
- Redirect and ex_stall in the same cycle: ex_stall wins; the redirect is withheld until the cycle in which it is accepted.
- Reset (synchronous, reset==0 at the edge):
  - state=RUN, cnt=0.
  - id_ex_instruc=0, id_ex_nextpc=0, id_ex_valid=0.
  - Combinational outputs read 0 while reset is low.
  - A mid-squash reset abandons the squash.
- Instruction 32'h0 decodes as a NOP (sll $0) and is valid.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- When defined: MIPS delay-slot semantics. The instruction fetched after a branch executes, SQUASH_CYCLES is effectively 0 for branches and jumps, and SYSCALL still goes to EXC_WAIT.
- When undefined: wrong-path squash exactly as above.

Decomposition:
- Package decode_pkg holds:
  - Opcode and funct constants.
  - SELPC_REL/REG/IDX/EXC = 2'b00/01/10/11.
  - State enum RUN/SQUASH/EXC_WAIT.
- Sub-module branch_target_calc, purely combinational: computes pcimd2ext, pcindex and taken from instr, nextpc and operands.

Test Plan:
- Reset with reset=0 for 2 cycles → id_ex_valid=0, id_ex_nextpc=0, id_if_selpcsource=0.
- BEQ imm=16'hFFFE, nextpc=0x100, rs=rt=5 → selpcsource=1, type=00, pcimd2ext=0xF8. The next cycle's instruction is not valid; valid=1 resumes after that.
- BNE with rs=rt=7 → no redirect, id_ex_valid=1, no squash.
- JR with rs_busy=1 for 3 cycles, rs_data=0x200 → id_stall=1 for 3 cycles with 3 bubbles, then redirect with type=01 and rega=0x200.
- J instr=0x0800_0010, nextpc=0x1000_0004 → type=10, pcindex=0x1000_0040. The same test with DELAY_SLOT_EN defined shows the following instruction valid=1.
- SYSCALL with ex_stall=1 for 2 cycles → no redirect during the stall, then type=11, EXC_WAIT bubble, and RUN state again.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode constants, FSM states and the ID/EX bundle.
// Used by decode_branch_unit and branch_target_calc.
package decode_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  localparam logic [1:0] SELPC_REL = 2'b00;
  localparam logic [1:0] SELPC_REG = 2'b01;
  localparam logic [1:0] SELPC_IDX = 2'b10;
  localparam logic [1:0] SELPC_EXC = 2'b11;

  typedef enum logic [1:0] {
    RUN,
    SQUASH,
    EXC_WAIT
  } state_t;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_JMP,
    BR_JR,
    BR_SYS
  } br_t;

  typedef struct packed {
    logic [31:0] instruc;
    logic [31:0] nextpc;
    logic        valid;
  } id_ex_t;

  function automatic br_t br_class(
    input logic [31:0] instr
  );
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    br_class = BR_NONE;
    unique case (1'b1)
      (op == OP_BEQ): br_class = BR_BEQ;
      (op == OP_BNE): br_class = BR_BNE;
      (op == OP_J),
      (op == OP_JAL): br_class = BR_JMP;
      (op == OP_SPECIAL && fn == FN_JR):
        br_class = BR_JR;
      (op == OP_SPECIAL && fn == FN_SYSCALL):
        br_class = BR_SYS;
      default: br_class = BR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch/jump target and taken evaluation.
// Pure datapath, no state.
module branch_target_calc
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] nextpc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] pcimd2ext,
  output logic [31:0] pcindex,
  output logic        taken
);

  br_t cls;

  assign cls = br_class(instr);

  assign pcimd2ext = nextpc +
    {{14{instr[15]}}, instr[15:0], 2'b00};

  assign pcindex = {nextpc[31:28],
                    instr[25:0], 2'b00};

  // branch condition per instruction class
  always_comb begin
    taken = 1'b0;
    unique case (cls)
      BR_BEQ:  taken = (rs_data == rt_data);
      BR_BNE:  taken = (rs_data != rt_data);
      BR_JMP,
      BR_JR,
      BR_SYS:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_branch_unit.sv
// Decode-side branch resolution, fetch redirect and ID/EX latch.
// Define DELAY_SLOT_EN for MIPS delay-slot semantics (no squash).
module decode_branch_unit
  import decode_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
  parameter int unsigned SQUASH_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] if_id_instruc,
  input  logic [31:0] if_id_nextpc,
  output logic [4:0]  rf_rs_addr,
  output logic [4:0]  rf_rt_addr,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  input  logic        rs_busy,
  input  logic        rt_busy,
  input  logic        ex_stall,
  output logic        id_stall,
  output logic        id_if_selpcsource,
  output logic [1:0]  id_if_selpctype,
  output logic [31:0] id_if_pcimd2ext,
  output logic [31:0] id_if_pcindex,
  output logic [31:0] id_if_rega,
  output logic [31:0] id_ex_instruc,
  output logic [31:0] id_ex_nextpc,
  output logic        id_ex_valid
);

  if (SQUASH_CYCLES < 1 || SQUASH_CYCLES > 2 ||
      EXC_VECTOR[1:0] != 2'b00) begin : g_bad_param
    $error("decode_branch_unit: bad parameter");
  end

  state_t      state;
  logic [1:0]  cnt;
  id_ex_t      id_ex;
  br_t         cls;
  logic        run;
  logic        need_rs;
  logic        need_rt;
  logic        hazard;
  logic        taken;
  logic        redirect;
  logic [1:0]  sel_type;
  logic [31:0] calc_imd;
  logic [31:0] calc_idx;

  branch_target_calc u_calc (
    .instr     (if_id_instruc),
    .nextpc    (if_id_nextpc),
    .rs_data   (rf_rs_data),
    .rt_data   (rf_rt_data),
    .pcimd2ext (calc_imd),
    .pcindex   (calc_idx),
    .taken     (taken)
  );

  assign cls = br_class(if_id_instruc);
  assign run = (state == RUN);

  // operand needs, hazard and redirect qualification
  always_comb begin
    need_rs  = cls inside {BR_BEQ, BR_BNE, BR_JR};
    need_rt  = cls inside {BR_BEQ, BR_BNE};
    hazard   = reset & run &
               ((need_rs & rs_busy) |
                (need_rt & rt_busy));
    redirect = reset & run & ~hazard &
               ~ex_stall & taken;
  end

  // fetch target kind for the current class
  always_comb begin
    sel_type = SELPC_REL;
    unique case (cls)
      BR_JMP:  sel_type = SELPC_IDX;
      BR_JR:   sel_type = SELPC_REG;
      BR_SYS:  sel_type = SELPC_EXC;
      default: sel_type = SELPC_REL;
    endcase
  end

  assign id_stall          = reset & (hazard | ex_stall);
  assign id_if_selpcsource = redirect;
  assign id_if_selpctype   = redirect ? sel_type : 2'b00;
  assign id_if_pcimd2ext   = reset ? calc_imd : '0;
  assign id_if_pcindex     = reset ? calc_idx : '0;
  assign id_if_rega        = reset ? rf_rs_data : '0;
  assign rf_rs_addr = reset ? if_id_instruc[25:21] : '0;
  assign rf_rt_addr = reset ? if_id_instruc[20:16] : '0;

  assign id_ex_instruc = id_ex.instruc;
  assign id_ex_nextpc  = id_ex.nextpc;
  assign id_ex_valid   = id_ex.valid;

  // squash FSM and ID/EX latch; ex_stall freezes both
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
      id_ex <= '0;
    end else if (!ex_stall) begin
      unique case (state)
        RUN: begin
          if (hazard) begin
            id_ex <= '0;
          end else begin
            id_ex.instruc <= if_id_instruc;
            id_ex.nextpc  <= if_id_nextpc;
            id_ex.valid   <= 1'b1;
            if (redirect) begin
              if (cls == BR_SYS) begin
                state <= EXC_WAIT;
              end else begin
`ifdef DELAY_SLOT_EN
                state <= RUN;
`else
                state <= SQUASH;
                cnt   <= SQUASH_CYCLES[1:0];
`endif
              end
            end
          end
        end
        SQUASH: begin
          id_ex <= '0;
          cnt   <= cnt - 2'd1;
          if (cnt <= 2'd1) state <= RUN;
        end
        EXC_WAIT: begin
          id_ex <= '0;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
